// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the round-robin memory controller.
// Memory geometry, the controller state encoding and the read-tag layout live here.
package mem_ctrl_pkg;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic       is_read;
        logic [1:0] id;
    } mem_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or above i_ptr, with wrap.
// Zero latency; o_vld is low and o_grant is zero when nothing requests.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [1:0]         i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [1:0]         o_idx,
    output logic               o_vld
);

    logic       w_hi_found;
    logic       w_lo_found;
    logic [1:0] w_hi_idx;
    logic [1:0] w_lo_idx;

    // Lowest request at/above the pointer wins; otherwise wrap to the lowest request overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = 2'd0;
        w_lo_idx   = 2'd0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (i_req[j] && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo_idx   = 2'(j);
            end
            if (i_req[j] && (2'(j) >= i_ptr) && !w_hi_found) begin
                w_hi_found = 1'b1;
                w_hi_idx   = 2'(j);
            end
        end
        o_idx = w_hi_found ? w_hi_idx : w_lo_idx;
        o_vld = w_lo_found;
        for (int j = 0; j < NUM_REQ; j++) begin
            o_grant[j] = w_lo_found && (o_idx == 2'(j));
        end
    end

endmodule

// File: rtl/mem_rr_ctrl.sv
// Round-robin front end for the 16x32 single-port memory, with a zero-fill CLEAR sequencer.
// Read data returns two edges after accept; req_ready is one-hot and held low during CLEAR.
module mem_rr_ctrl #(
    parameter int NUM_REQ = 2,
    parameter int AW      = mem_ctrl_pkg::AW,
    parameter int DW      = mem_ctrl_pkg::DW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ-1:0][AW-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DW-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DW-1:0]               rsp_rdata,
    input  logic                        clear_start,
    output logic                        clear_busy,
    output logic                        clear_done,
    output logic                        mem_wenable,
    output logic                        mem_renable,
    output logic [AW-1:0]               mem_addr,
    output logic [DW-1:0]               mem_data_in,
    input  logic [DW-1:0]               mem_data_out
);

    import mem_ctrl_pkg::*;

    ctrl_state_e         r_state;
    ctrl_state_e         w_state_nxt;
    logic [1:0]          r_ptr;
    logic [1:0]          w_ptr_nxt;
    logic [AW-1:0]       r_clr_cnt;
    logic [AW-1:0]       w_clr_cnt_nxt;
    logic                w_clear_done_nxt;

    logic                w_arb_vld;
    logic [1:0]          w_arb_idx;
    logic [NUM_REQ-1:0]  w_arb_grant;

    logic                w_issue_we;
    logic                w_issue_re;
    logic [AW-1:0]       w_issue_addr;
    logic [DW-1:0]       w_issue_data;
    mem_tag_t            w_tag_in;
    mem_tag_t            r_tag0;
    mem_tag_t            r_tag1;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_vld   (w_arb_vld)
    );

    assign clear_busy = (r_state == CLEAR);

    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_clr_cnt_nxt    = r_clr_cnt;
        w_clear_done_nxt = 1'b0;
        req_ready        = '0;
        w_issue_we       = 1'b0;
        w_issue_re       = 1'b0;
        w_issue_addr     = '0;
        w_issue_data     = '0;
        w_tag_in         = '0;
        case (r_state)
            IDLE: begin
                // A clear request pre-empts arbitration for this cycle.
                if (clear_start) begin
                    w_state_nxt   = CLEAR;
                    w_clr_cnt_nxt = '0;
                end else if (w_arb_vld && !rst) begin
                    req_ready = w_arb_grant;
                    w_ptr_nxt = (w_arb_idx == 2'(NUM_REQ - 1)) ? 2'd0 : w_arb_idx + 2'd1;
                    for (int j = 0; j < NUM_REQ; j++) begin
                        if (w_arb_grant[j]) begin
                            w_issue_we   = req_write[j];
                            w_issue_re   = !req_write[j];
                            w_issue_addr = req_addr[j];
                            w_issue_data = req_wdata[j];
                        end
                    end
                    w_tag_in.is_read = w_issue_re;
                    w_tag_in.id      = w_arb_idx;
                end
            end
            CLEAR: begin
                w_issue_we    = 1'b1;
                w_issue_addr  = r_clr_cnt;
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == '1) begin
                    w_state_nxt      = IDLE;
                    w_clear_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= 2'd0;
            r_clr_cnt   <= '0;
            clear_done  <= 1'b0;
            mem_wenable <= 1'b0;
            mem_renable <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            r_tag0      <= '0;
            r_tag1      <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            clear_done  <= w_clear_done_nxt;
            mem_wenable <= w_issue_we;
            mem_renable <= w_issue_re;
            mem_addr    <= w_issue_addr;
            mem_data_in <= w_issue_data;
            // Tag stage 1 lines up with the memory's registered read data.
            r_tag0      <= w_tag_in;
            r_tag1      <= r_tag0;
            for (int j = 0; j < NUM_REQ; j++) begin
                rsp_valid[j] <= r_tag1.is_read && (r_tag1.id == 2'(j));
            end
            if (r_tag1.is_read) begin
                rsp_rdata <= mem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_mem_rr_ctrl.sv
// Scoreboard bench for mem_rr_ctrl with a behavioural 16x32 registered-read memory.
module tb_mem_rr_ctrl;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_write = '0;
    logic [1:0][3:0]   req_addr  = '0;
    logic [1:0][31:0]  req_wdata = '0;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              clear_start = 1'b0;
    logic              clear_busy;
    logic              clear_done;
    logic              mem_wenable;
    logic              mem_renable;
    logic [3:0]        mem_addr;
    logic [31:0]       mem_data_in;
    logic [31:0]       mem_data_out = '0;

    logic [31:0]       mem_model [16];

    typedef struct {
        logic [1:0]  oh;
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    mem_rr_ctrl #(.NUM_REQ(2), .AW(4), .DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .clear_start  (clear_start),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .mem_wenable  (mem_wenable),
        .mem_renable  (mem_renable),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_wenable) mem_model[mem_addr] <= mem_data_in;
        else if (mem_renable) mem_data_out <= mem_model[mem_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Response appears at the falling edge three posedges after the falling edge that saw the accept.
    task automatic push_exp(input logic [1:0] oh, input logic [31:0] d);
        exp_t e;
        e.oh = oh;
        e.d  = d;
        e.c  = cyc + 3;
        q.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the rising edge that accepted the request.
    task automatic do_req(input int id, input logic wr, input logic [3:0] a, input logic [31:0] d);
        bit ok = 0;
        req_valid = 2'(1 << id);
        req_write = {wr, wr};
        if (id == 0) begin req_addr[0] = a; req_wdata[0] = d; end
        else         begin req_addr[1] = a; req_wdata[1] = d; end
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (req_ready == 2'(1 << id)) begin
                ok = 1;
                if (!wr) push_exp(2'(1 << id), d);
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        chk("accept", 64'(ok), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_clear"}, {62'd0, clear_busy, clear_done}, 64'd0);
        chk({tag, "_mem_en"}, {62'd0, mem_wenable, mem_renable}, 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_din"}, 64'(mem_data_in), 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid != 2'b00) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", {30'd0, rsp_valid, rsp_rdata}, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_id", 64'(rsp_valid), 64'(e.oh));
                    chk("rsp_data", 64'(rsp_rdata), 64'(e.d));
                    chk("rsp_cycle", 64'(cyc), 64'(e.c));
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  busy_n, done_n, wr_n, exp_a;
        bit  seen;

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Single write then read
        do_req(0, 1'b1, 4'd3, 32'hDEADBEEF);
        do_req(0, 1'b0, 4'd3, 32'hDEADBEEF);
        do_req(1, 1'b1, 4'd5, 32'hA5A50005);

        // Contention: pointer is 0, grants alternate 0,1,0,1
        req_write = 2'b00;
        req_addr[0] = 4'd3;
        req_addr[1] = 4'd5;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_grant", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            if (k % 2 == 0) push_exp(2'b01, 32'hDEADBEEF);
            else            push_exp(2'b10, 32'hA5A50005);
            @(posedge clk); #1;
        end
        req_valid = '0;

        // Write-then-read hazard on address 7
        req_valid = 2'b10;
        req_write = 2'b10;
        req_addr[1] = 4'd7;
        req_wdata[1] = 32'h12345678;
        @(negedge clk);
        chk("hazard_wr_grant", 64'(req_ready), 64'd2);
        @(posedge clk); #1;
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr[0] = 4'd7;
        @(negedge clk);
        chk("hazard_rd_grant", 64'(req_ready), 64'd1);
        push_exp(2'b01, 32'h12345678);
        @(posedge clk); #1;
        req_valid = '0;

        // Fill every word with nonzero data
        for (int i = 0; i < 16; i++) do_req(0, 1'b1, 4'(i), 32'h10000001 + 32'(i));
        repeat (3) @(posedge clk); #1;

        // CLEAR with both requesters asking
        req_valid = 2'b11;
        req_write = 2'b00;
        req_addr[0] = 4'd0;
        req_addr[1] = 4'd0;
        clear_start = 1'b1;
        @(negedge clk);
        chk("clear_no_grant", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        clear_start = 1'b0;
        req_valid = '0;
        busy_n = 0; done_n = 0; wr_n = 0; exp_a = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (clear_busy) busy_n++;
            if (clear_done) begin
                done_n++;
                chk("busy_low_at_done", 64'(clear_busy), 64'd0);
            end
            if (mem_wenable) begin
                chk("clear_addr", 64'(mem_addr), 64'(exp_a));
                chk("clear_data", 64'(mem_data_in), 64'd0);
                exp_a++;
                wr_n++;
            end
            chk("clear_no_read", 64'(mem_renable), 64'd0);
            clear_start = (k == 4);
        end
        clear_start = 1'b0;
        chk("clear_busy_cycles", 64'(busy_n), 64'd16);
        chk("clear_done_pulses", 64'(done_n), 64'd1);
        chk("clear_writes", 64'(wr_n), 64'd16);
        @(posedge clk); #1;

        // Pointer untouched by CLEAR: it was 1, so requester 1 wins
        req_valid = 2'b11;
        @(negedge clk);
        chk("post_clear_grant", 64'(req_ready), 64'd2);
        push_exp(2'b10, 32'h0);
        @(posedge clk); #1;
        req_valid = '0;

        for (int i = 0; i < 16; i++) do_req(0, 1'b0, 4'(i), 32'h0);

        // Read in flight when CLEAR starts still returns pre-clear data
        do_req(0, 1'b1, 4'd9, 32'h09090909);
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr[0] = 4'd9;
        @(negedge clk);
        chk("inflight_grant", 64'(req_ready), 64'd1);
        push_exp(2'b01, 32'h09090909);
        @(posedge clk); #1;
        req_valid = '0;
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (clear_done) seen = 1;
        end
        chk("clear2_done", 64'(seen), 64'd1);
        @(posedge clk); #1;
        do_req(0, 1'b0, 4'd9, 32'h0);
        repeat (4) @(posedge clk); #1;

        // Reset between a read accept and its response
        req_valid = 2'b01;
        req_addr[0] = 4'd2;
        @(negedge clk);
        chk("rst_rd_grant", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk); #1;
        req_valid = 2'b11;
        req_addr[0] = 4'd0;
        req_addr[1] = 4'd0;
        @(negedge clk);
        chk("first_grant_after_rst", 64'(req_ready), 64'd1);
        push_exp(2'b01, 32'h0);
        @(posedge clk); #1;
        req_valid = '0;

        repeat (10) @(posedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_rr_ctrl.md
Name: mem_rr_ctrl

Overview:
- Round-robin access controller for the 16x32 single-port memory (wenable/renable/addr/data_in in; data_out/valid_out out).
- Shares the memory between NUM_REQ requesters over a valid/ready request interface and routes read data back to the requester that issued the read.
- Includes a CLEAR sequencer that writes zero to all 16 words on command, without pulsing the memory's own reset.
- Sits directly in front of the memory instance; it is the only driver of the memory's control and data inputs.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- AW, 4, address width; depth = 2**AW = 16.
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all registers are rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  request present, one bit per requester.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ x AW  word address.
- req_wdata  in  NUM_REQ x DW  write data.
- req_ready  out  NUM_REQ  one-hot grant; a request is accepted when valid && ready at a clock edge.
- rsp_valid  out  NUM_REQ  one-cycle pulse per read response.
- rsp_rdata  out  DW  read data, shared by all requesters; qualified by rsp_valid.
- clear_start  in  1  pulse that starts the CLEAR sequence.
- clear_busy  out  1  high while the CLEAR sequence runs.
- clear_done  out  1  one-cycle pulse when CLEAR completes.
- mem_wenable, mem_renable  out  1  memory write/read enables, registered.
- mem_addr  out  AW  memory address, registered.
- mem_data_in  out  DW  memory write data, registered.
- mem_data_out  in  DW  memory read data.

Behaviour:
- Reset: all outputs 0, state = IDLE, RR pointer = 0, clear counter = 0, pipeline tags cleared. Reset mid-operation drops in-flight responses; no rsp_valid is emitted for them.
- The memory's valid_out is sticky, so it is not used. Response timing comes from an internal tag pipeline.
- Arbitration in IDLE:
  - req_ready is combinational and one-hot.
  - Grant goes to the first asserted req_valid, searching from the RR pointer upward with wrap.
  - On acceptance the pointer moves to granted index + 1 (mod NUM_REQ).
  - The pointer holds when nothing is accepted.
  - At most one request is accepted per cycle, giving full throughput with back-to-back accepts.
- Issue timing:
  - Request accepted at edge E0; mem_* registers load at E0.
  - The memory samples them at E1.
  - mem_data_out is captured into rsp_rdata at E2.
  - rsp_valid[id] is high for the one cycle after E2.
  - Read latency is 2 cycles from accept edge to response cycle.
- When no request is accepted, mem_wenable and mem_renable are both 0 in the next cycle. The two enables are never both 1.
- Ordering: memory ops execute in accept order. A read accepted the cycle after a write to the same address returns the new data.
- Writes produce no response.
- The tag pipeline is 2 stages of {is_read, id}.
- CLEAR FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clear_start = 1.
    - clear_start wins over any req_valid that cycle: no grant is given.
    - clear_busy is high from the next cycle.
  - In CLEAR: req_ready = 0. The controller issues writes of 0 to addresses 0..15, one per cycle, on consecutive cycles.
  - Reads accepted before entering CLEAR still complete and respond normally.
  - After the write to address 15 is issued: CLEAR -> IDLE, clear_done pulses for 1 cycle, clear_busy drops in the same cycle, and arbitration resumes in the next cycle.
  - clear_start while in CLEAR is ignored.
  - The RR pointer is unchanged by CLEAR.
- Address width: no range check needed, since AW covers the full depth.

Decomposition:
- Package mem_ctrl_pkg holds:
  - AW, DW, and the depth constant;
  - the state enum ctrl_state_e {IDLE, CLEAR};
  - the struct mem_tag_t {logic is_read; logic [1:0] id}.
- One sub-module, rr_arbiter: NUM_REQ request vector + pointer in, one-hot grant + encoded index out, combinational. It is reused later by other shared resources.
- The FSM, clear counter, issue registers and tag pipeline stay in mem_rr_ctrl.

Test Plan:
- Reset then single read: req0 write addr 3 data 0xDEADBEEF, then req0 read addr 3 -> rsp_valid[0] 2 cycles after accept, rsp_rdata = 0xDEADBEEF.
- Contention: req0 and req1 hold read requests every cycle -> grants alternate 0,1,0,1 with pointer starting at 0; each rsp_valid pulse goes to the matching requester.
- Write-then-read hazard: req1 write addr 7 = 0x12345678, accepted at cycle N; req0 read addr 7 accepted at N+1 -> rsp_rdata = 0x12345678.
- CLEAR: fill all 16 words with nonzero data, pulse clear_start with req_valid=2'b11 -> no grant that cycle, clear_busy high 16 cycles with addresses 0..15 in order, clear_done single pulse, then reads of every address return 0.
- Read in flight at CLEAR entry: read accepted the cycle clear_start arrives in the following cycle -> its response is still delivered with the pre-clear data.
- Asynchronous reset asserted mid-way between a read accept and its response -> no rsp_valid; all outputs 0 immediately; first grant after reset goes to req0.
